writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order pipeline writeback and a
//  long-latency unit (divider/CSR/late load) that returns results out of band. The pipeline has
//  priority. Late results are buffered in a small FIFO, and a starvation timer forces a one-cycle
//  pipeline stall to drain them. Sits between the writeback-source mux and the register file.
// PARAMETERS
//  DATA_WIDTH   32  register/result width
//  REG_AW       5   register address width (32 architectural regs, x0 hard-wired zero)
//  QUEUE_DEPTH  2   late-result FIFO entries (power of 2, >=2)
//  MAX_WAIT     4   cycles a non-empty queue head may lose arbitration before a forced drain
// PORTS
//  clock            in   1           core clock
//  reset            in   1           synchronous, active-high
//  wb_valid         in   1           pipeline writeback valid (already muxed ALU/mem/PC+4)
//  wb_rd            in   REG_AW      pipeline destination register
//  wb_data          in   DATA_WIDTH  pipeline write data
//  lu_valid         in   1           long-latency result valid
//  lu_ready         out  1           arbiter can accept a late result (= !full, registered)
//  lu_rd            in   REG_AW      late-result destination register
//  lu_data          in   DATA_WIDTH  late-result data
//  rf_write_enable  out  1           register-file write strobe (registered)
//  rf_write_address out  REG_AW      register-file write address (registered)
//  rf_write_data    out  DATA_WIDTH  register-file write data (registered)
//  pipe_stall       out  1           hold writeback/upstream stages this cycle (forced drain)
//  pending_rd_mask  out  2**REG_AW   bit r set while a queued result targets xr (issue scoreboard)
// BEHAVIOUR
//  - Reset: queue empty, wait counter 0, state IDLE; rf_write_enable=0, rf_write_address=0,
//    rf_write_data=0, pipe_stall=0, lu_ready=1, pending_rd_mask=0. Reset mid-operation discards
//    all queued results without writing them.
//  - Latency: a granted write appears on rf_* exactly 1 cycle after selection.
//  - Enqueue on lu_valid&&lu_ready. lu_rd==0 is accepted and dropped (no entry, no mask bit).
//    When full, lu_ready=0 even if a dequeue happens that cycle (no same-cycle pass-through).
//  - Grant per cycle: state DRAIN -> queue head (wb_valid ignored; pipeline re-presents it next
//    cycle). Otherwise wb_valid with wb_rd!=0 -> pipeline. Otherwise non-empty queue -> head.
//    Otherwise rf_write_enable=0 next cycle. wb_valid with wb_rd==0 counts as no request.
//  - No bypass: a late result needs >=1 cycle in the queue, so the earliest rf write is 2 cycles
//    after its handshake.
//  - pending_rd_mask: bit set on enqueue and cleared on the cycle the entry is granted. The issue
//    stage guarantees no WAW: no duplicate rd in the queue and no pipeline rd that matches a set bit.
//  - FSM (registered state; pipe_stall = state==DRAIN):
//    IDLE : queue empty. Enqueue -> WAIT with wait_cnt=0.
//    WAIT : head loses to the pipeline -> wait_cnt++. wait_cnt reaches MAX_WAIT-1 with another
//           loss -> DRAIN. Head granted -> wait_cnt=0; queue then empty -> IDLE, else stay WAIT.
//    DRAIN: single cycle. Head granted, wait_cnt=0; queue then empty -> IDLE, else -> WAIT.
//  - Simultaneous enqueue and dequeue with a non-full queue: both occur, and the count is unchanged.
//  - Counters saturate; no wrap of wait_cnt beyond MAX_WAIT.
// STRUCTURE
//  - Package writeback_arbiter_pkg: state enum {IDLE,WAIT,DRAIN}, the late-result entry struct
//    {rd,data}, and defaults for DATA_WIDTH/REG_AW.
//  - Sub-module wb_result_fifo: QUEUE_DEPTH-entry synchronous FIFO (push/pop/full/empty/head)
//    with wrap-around pointers. The arbiter holds the FSM, grant mux, output registers and mask.
// TESTING
//  1 Reset: hold reset 2 cycles while lu_valid=1 -> all outputs at reset values and nothing
//    enqueued; after release lu_ready=1.
//  2 Pipeline only: wb_valid, rd=5, data=0xDEADBEEF -> next cycle rf_write_enable=1, addr=5,
//    data=0xDEADBEEF. rd=0 -> rf_write_enable=0.
//  3 Idle late path: lu handshake rd=7, data=0x11 at cycle t with no wb_valid -> mask bit7=1 at
//    t+1; rf write of x7=0x11 at t+2; bit7 clears.
//  4 Starvation: enqueue rd=9, then wb_valid every cycle -> after 4 losses pipe_stall=1 for one
//    cycle, x9 written next, and the pipeline write held during the stall lands the cycle after.
//  5 Full: two enqueues (rd=3,4) under continuous wb_valid -> lu_ready=0. A third lu_valid is
//    not accepted until a dequeue; drain order is x3 then x4.
//  6 Reset mid-operation: queue holds 2 entries and state is DRAIN; assert reset -> no rf write,
//    mask=0, pipe_stall=0 next cycle.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
package writeback_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_REG_AW     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [DEF_REG_AW-1:0]     rd;
    logic [DEF_DATA_WIDTH-1:0] data;
  } late_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding late results until they win the write port.
module wb_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; no reset needed since count gates visibility.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between pipeline writeback and late results.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned REG_AW      = DEF_REG_AW,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [REG_AW-1:0]        wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [REG_AW-1:0]        lu_rd,
  input  logic [DATA_WIDTH-1:0]    lu_data,
  output logic                     rf_write_enable,
  output logic [REG_AW-1:0]        rf_write_address,
  output logic [DATA_WIDTH-1:0]    rf_write_data,
  output logic                     pipe_stall,
  output logic [(1<<REG_AW)-1:0]   pending_rd_mask
);

  localparam int unsigned ENTRY_W = REG_AW + DATA_WIDTH;
  localparam int unsigned CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned WCW     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned NREG    = 1 << REG_AW;

  arb_state_e          state;
  arb_state_e          state_next;
  logic [WCW-1:0]      wait_cnt;
  logic [WCW-1:0]      wait_cnt_next;
  logic                q_full;
  logic                q_empty;
  logic [ENTRY_W-1:0]  q_head;
  logic [CW-1:0]       q_count;
  logic [CW-1:0]       count_after;
  logic [REG_AW-1:0]   head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic                pipe_req;
  logic                push;
  logic                grant_lu;
  logic                grant_wb;
  logic                head_lost;
  logic [NREG-1:0]     mask_next;

  assign head_rd   = q_head[ENTRY_W-1 -: REG_AW];
  assign head_data = q_head[DATA_WIDTH-1:0];

  wb_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({lu_rd, lu_data}),
    .pop       (grant_lu),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head),
    .count     (q_count)
  );

  // Grant selection: forced drain beats pipeline, pipeline beats queue; x0 writes are dropped.
  always_comb begin
    pipe_req    = wb_valid && (wb_rd != '0);
    push        = lu_valid && lu_ready && !q_full && (lu_rd != '0);
    grant_lu    = !q_empty && ((state == DRAIN) || !pipe_req);
    grant_wb    = (state != DRAIN) && pipe_req;
    head_lost   = !q_empty && !grant_lu;
    count_after = q_count + CW'(push) - CW'(grant_lu);
  end

  // Starvation FSM: count head losses and force a one-cycle drain at the limit.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (push) begin
          state_next    = WAIT;
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (grant_lu) begin
          wait_cnt_next = '0;
          state_next    = (count_after == '0) ? IDLE : WAIT;
        end else if (head_lost) begin
          if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
            state_next = DRAIN;
          end else begin
            wait_cnt_next = wait_cnt + WCW'(1);
          end
        end
      end
      DRAIN: begin
        wait_cnt_next = '0;
        state_next    = (count_after == '0) ? IDLE : WAIT;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Pending-destination mask: clear the granted head, set the newly queued rd.
  always_comb begin
    mask_next = pending_rd_mask;
    if (grant_lu) mask_next[head_rd] = 1'b0;
    if (push)     mask_next[lu_rd]   = 1'b1;
  end

  // State and registered outputs; reset discards everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      rf_write_enable  <= 1'b0;
      rf_write_address <= '0;
      rf_write_data    <= '0;
      pipe_stall       <= 1'b0;
      lu_ready         <= 1'b1;
      pending_rd_mask  <= '0;
    end else begin
      state           <= state_next;
      wait_cnt        <= wait_cnt_next;
      pipe_stall      <= (state_next == DRAIN);
      lu_ready        <= (count_after != CW'(QUEUE_DEPTH));
      pending_rd_mask <= mask_next;
      rf_write_enable <= grant_wb || grant_lu;
      if (grant_wb) begin
        rf_write_address <= wb_rd;
        rf_write_data    <= wb_data;
      end else if (grant_lu) begin
        rf_write_address <= head_rd;
        rf_write_data    <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: queue-level reference model plus write monitor.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int unsigned QD   = 2;
  localparam int unsigned MAXW = 4;

  logic        clock;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_data;
  logic        pipe_stall;
  logic [31:0] pending_rd_mask;

  writeback_arbiter #(
    .DATA_WIDTH  (32),
    .REG_AW      (5),
    .QUEUE_DEPTH (QD),
    .MAX_WAIT    (MAXW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .lu_valid         (lu_valid),
    .lu_ready         (lu_ready),
    .lu_rd            (lu_rd),
    .lu_data          (lu_data),
    .rf_write_enable  (rf_write_enable),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .pipe_stall       (pipe_stall),
    .pending_rd_mask  (pending_rd_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  late_entry_t mq[$];
  int          m_loss;
  bit          m_drain;
  int          cyc;
  int          errors;
  int          checks;
  bit          chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    return m;
  endfunction

  function automatic bit in_queue(input logic [4:0] r);
    foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] pick_rd();
    logic [4:0] r;
    for (int t = 0; t < 16; t++) begin
      r = 5'($urandom_range(0, 31));
      if (!in_queue(r)) return r;
    end
    return 5'd0;
  endfunction

  // One cycle: check visible outputs, drive inputs, advance the model, step to the next negedge.
  task automatic step(input logic rst, input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    bit   ready;
    bit   pipe;
    exp_t e;
    ready = (mq.size() < QD);
    if (chk_en) begin
      chk("lu_ready", 32'(lu_ready), 32'(ready));
      chk("pipe_stall", 32'(pipe_stall), 32'(m_drain));
      chk("pending_mask", pending_rd_mask, model_mask());
    end
    reset = rst; wb_valid = wv; wb_rd = wr; wb_data = wd;
    lu_valid = lv; lu_rd = lr; lu_data = ld;
    if (rst) begin
      mq.delete();
      m_loss  = 0;
      m_drain = 1'b0;
    end else begin
      pipe = wv && (wr != 5'd0);
      if (m_drain && mq.size() > 0) begin
        e.due = cyc + 1; e.rd = mq[0].rd; e.data = mq[0].data;
        sb.push_back(e);
        void'(mq.pop_front());
        m_loss  = 0;
        m_drain = 1'b0;
      end else if (pipe) begin
        e.due = cyc + 1; e.rd = wr; e.data = wd;
        sb.push_back(e);
        if (mq.size() > 0) begin
          m_loss++;
          if (m_loss == MAXW) m_drain = 1'b1;
        end
      end else if (mq.size() > 0) begin
        e.due = cyc + 1; e.rd = mq[0].rd; e.data = mq[0].data;
        sb.push_back(e);
        void'(mq.pop_front());
        m_loss = 0;
      end
      if (lv && ready && lr != 5'd0) mq.push_back('{rd: lr, data: ld});
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every rf write must match the oldest expected write, on its due cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missing_write: expected x%0d=%0h at cycle %0d", sb[0].rd, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
      if (rf_write_enable === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got x%0d=%0h at cycle %0d expected no write", rf_write_address, rf_write_data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.due != cyc || rf_write_address !== e.rd || rf_write_data !== e.data) begin
            errors++;
            $display("FAIL rf_write: got x%0d=%0h at cycle %0d expected x%0d=%0h at cycle %0d",
                     rf_write_address, rf_write_data, cyc, e.rd, e.data, e.due);
          end
        end
      end else if (rf_write_enable !== 1'b0) begin
        checks++; errors++;
        $display("FAIL rf_write_enable: got %b expected 0 or 1", rf_write_enable);
      end
    end
  end

  initial begin
    logic        r, wv, lv;
    logic [4:0]  wr, lr;
    logic [31:0] wd, ld;
    errors = 0; checks = 0; cyc = 0; chk_en = 1'b0;
    m_loss = 0; m_drain = 1'b0;

    // Reset held two cycles with lu_valid asserted.
    reset = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h55;
    @(negedge clock);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55);
    chk("rst_we", 32'(rf_write_enable), 32'd0);
    chk("rst_addr", 32'(rf_write_address), 32'd0);
    chk("rst_data", rf_write_data, 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_mask", pending_rd_mask, 32'd0);
    chk("rst_ready", 32'(lu_ready), 32'd1);
    idle(1);
    chk("rst_no_enqueue", pending_rd_mask, 32'd0);

    // Pipeline only, including an x0 writeback.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("pipe_we", 32'(rf_write_enable), 32'd1);
    chk("pipe_addr", 32'(rf_write_address), 32'd5);
    chk("pipe_data", rf_write_data, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    chk("pipe_x0_we", 32'(rf_write_enable), 32'd0);

    // Idle late path: handshake, mask next cycle, write one cycle later.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    chk("late_mask_set", pending_rd_mask, 32'h80);
    chk("late_no_bypass", 32'(rf_write_enable), 32'd0);
    idle(1);
    chk("late_addr", 32'(rf_write_address), 32'd7);
    chk("late_data", rf_write_data, 32'h11);
    chk("late_mask_clr", pending_rd_mask, 32'd0);

    // Starvation: four losses then a forced one-cycle drain.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 5'(10 + i), 32'(100 + i), 1'b0, 5'd0, 32'd0);
    chk("starve_stall", 32'(pipe_stall), 32'd1);
    step(1'b0, 1'b1, 5'd14, 32'h140, 1'b0, 5'd0, 32'd0);
    chk("starve_drain_addr", 32'(rf_write_address), 32'd9);
    chk("starve_stall_clr", 32'(pipe_stall), 32'd0);
    step(1'b0, 1'b1, 5'd14, 32'h140, 1'b0, 5'd0, 32'd0);
    chk("starve_replay_addr", 32'(rf_write_address), 32'd14);
    idle(2);

    // Full queue under continuous pipeline traffic.
    step(1'b0, 1'b1, 5'd20, 32'h200, 1'b1, 5'd3, 32'h33);
    step(1'b0, 1'b1, 5'd21, 32'h210, 1'b1, 5'd4, 32'h44);
    chk("full_ready0", 32'(lu_ready), 32'd0);
    step(1'b0, 1'b1, 5'd22, 32'h220, 1'b1, 5'd6, 32'h66);
    chk("full_ready_hold", 32'(lu_ready), 32'd0);
    chk("full_no_x6", 32'(pending_rd_mask[6]), 32'd0);
    step(1'b0, 1'b1, 5'd23, 32'h230, 1'b1, 5'd6, 32'h66);
    step(1'b0, 1'b1, 5'd24, 32'h240, 1'b1, 5'd6, 32'h66);
    step(1'b0, 1'b1, 5'd24, 32'h240, 1'b1, 5'd6, 32'h66);
    chk("full_drain_x3", 32'(rf_write_address), 32'd3);
    step(1'b0, 1'b1, 5'd24, 32'h240, 1'b1, 5'd6, 32'h66);
    idle(1);
    chk("full_then_x4", 32'(rf_write_address), 32'd4);
    idle(3);

    // Reset in the middle of a forced drain with two queued entries.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC);
    step(1'b0, 1'b1, 5'd20, 32'h20, 1'b1, 5'd13, 32'hD);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'(21 + i), 32'(i), 1'b0, 5'd0, 32'd0);
    chk("mid_stall", 32'(pipe_stall), 32'd1);
    chk("mid_mask", pending_rd_mask, 32'h3000);
    step(1'b1, 1'b1, 5'd24, 32'h24, 1'b0, 5'd0, 32'd0);
    chk("mid_rst_we", 32'(rf_write_enable), 32'd0);
    chk("mid_rst_mask", pending_rd_mask, 32'd0);
    chk("mid_rst_stall", 32'(pipe_stall), 32'd0);
    idle(3);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 149) == 0);
      wv = ($urandom_range(0, 99) < 70);
      wr = pick_rd();
      wd = $urandom;
      lv = ($urandom_range(0, 99) < 40);
      lr = pick_rd();
      ld = $urandom;
      step(r, wv, wr, wd, lv, lr, ld);
    end
    idle(8);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
